// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit timer, byte serializer, NRZI and differential pin drive.
// Optional bit stuffing is compiled in when TX_BIT_STUFF_EN is defined.
module usb_tx_line_encoder (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic       clear_timer,
  input  logic       load_enable,
  input  logic [7:0] data_pts,
  input  logic [2:0] state_val,
  output logic       shift_strobe,
  output logic       flag,
  output logic       dplus,
  output logic       dminus
);

  typedef enum logic [1:0] {
    LINE_J   = 2'd0,
    LINE_K   = 2'd1,
    LINE_SE0 = 2'd2
  } line_t;

  function automatic line_t toggled(input line_t l);
    return (l == LINE_J) ? LINE_K : LINE_J;
  endfunction

  logic [3:0] cnt;
  logic [1:0] ph;
  logic [3:0] period_last;

  line_t      line_q, line_d;
  logic [7:0] hold, hold_d;
  logic       hold_v, hold_v_d;
  logic [7:0] sr, sr_d;
  logic       sr_v, sr_v_d;
  logic [2:0] bc, bc_d;

  logic       st_idle, st_data, st_eop;
  logic       data_strobe, stuff, take_bit;

`ifdef TX_BIT_STUFF_EN
  logic [2:0] ones, ones_d;
`endif

  // Bit timer: 8 + 8 + 9 clocks = 3 bits per 25 clocks (12 Mb/s from 100 MHz)
  assign period_last  = (ph == 2'd2) ? 4'd8 : 4'd7;
  assign shift_strobe = enable_timer & ~clear_timer & (cnt == period_last);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
      ph  <= '0;
    end else if (clear_timer) begin
      cnt <= '0;
      ph  <= '0;
    end else if (shift_strobe) begin
      cnt <= '0;
      ph  <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    end else if (enable_timer) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign st_idle     = (state_val == 3'd0);
  assign st_eop      = (state_val >= 3'd6);
  assign st_data     = ~st_idle & ~st_eop;
  assign data_strobe = shift_strobe & st_data & sr_v;

`ifdef TX_BIT_STUFF_EN
  assign stuff = data_strobe & (ones == 3'd6);
`else
  assign stuff = 1'b0;
`endif

  assign take_bit = data_strobe & ~stuff;
  assign flag     = take_bit & (bc == 3'd7);

  always_comb begin
    line_d   = line_q;
    hold_d   = hold;
    hold_v_d = hold_v;
    sr_d     = sr;
    sr_v_d   = sr_v;
    bc_d     = bc;
`ifdef TX_BIT_STUFF_EN
    ones_d   = ones;
`endif
    if (st_idle) begin
      line_d = LINE_J;
      sr_v_d = 1'b0;
      bc_d   = '0;
`ifdef TX_BIT_STUFF_EN
      ones_d = '0;
`endif
    end else begin
      if (!sr_v && hold_v) begin
        sr_d     = hold;
        sr_v_d   = 1'b1;
        hold_v_d = 1'b0;
      end
      if (stuff) begin
        line_d = toggled(line_q);
`ifdef TX_BIT_STUFF_EN
        ones_d = '0;
`endif
      end else if (take_bit) begin
        if (!sr[0]) line_d = toggled(line_q);
`ifdef TX_BIT_STUFF_EN
        ones_d = sr[0] ? ones + 3'd1 : 3'd0;
`endif
        sr_d = {1'b0, sr[7:1]};
        bc_d = bc + 3'd1;
        // Last bit: chain the next byte straight from hold so no bit period is lost
        if (bc == 3'd7) begin
          if (hold_v) begin
            sr_d     = hold;
            hold_v_d = 1'b0;
          end else begin
            sr_v_d = 1'b0;
          end
        end
      end
      if (shift_strobe && st_eop) line_d = LINE_SE0;
    end
    if (load_enable) begin
      hold_d   = data_pts;
      hold_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_q <= LINE_J;
      dplus  <= 1'b1;
      dminus <= 1'b0;
      hold   <= '0;
      hold_v <= 1'b0;
      sr     <= '0;
      sr_v   <= 1'b0;
      bc     <= '0;
`ifdef TX_BIT_STUFF_EN
      ones   <= '0;
`endif
    end else begin
      line_q <= line_d;
      dplus  <= (line_d == LINE_J);
      dminus <= (line_d == LINE_K);
      hold   <= hold_d;
      hold_v <= hold_v_d;
      sr     <= sr_d;
      sr_v   <= sr_v_d;
      bc     <= bc_d;
`ifdef TX_BIT_STUFF_EN
      ones   <= ones_d;
`endif
    end
  end

endmodule
